// File: rtl/edac_err_logger.sv
// -----------------------------------------------------------------------------
// edac_err_logger
//
// Error-event logger placed directly after the EDAC core in the read-clock
// domain. Every read flagged as corrected (CE) or uncorrectable (UE) is
// counted in a saturating counter and recorded as {ue, scrub, address} in a
// small show-ahead FIFO that software drains through a pop interface. Any UE
// raises a sticky interrupt.
//
// Build option:
//   EDAC_ERRLOG_DEDUP_EN - when defined, an event whose {ue, addr} equals the
//                          last pushed entry is counted but not pushed again.
//                          The scrub bit is not part of the compare.
//
// Pipeline: all inputs are captured in one register stage and acted on at the
// following edge, so an event or pop sampled at edge N shows on the outputs
// after edge N+1. Events, pops, clr and irq_ack share that stage, which keeps
// their "same cycle" interactions aligned. No output depends combinationally
// on any input.
//
// Handshake: pop is a request, not a valid/ready pair. A pop that reaches the
// processing stage while the FIFO is empty is dropped with no side effects.
//
// FSM debug state: this block has no FSM; its whole state (pointers, counters,
// sticky flags) is already visible on the outputs.
//
// Ports:
//   rClk          in   sole clock, rising edge
//   nGrst         in   asynchronous active-low reset
//   correctable   in   EDAC: single-bit error corrected on this read
//   error         in   EDAC: uncorrectable error on this read
//   now_scrubbing in   EDAC: current read is a scrub read
//   ram_rA_lat    in   read address aligned with the flags
//   clr           in   synchronous clear of counters, FIFO, ovf, irq_ue
//   pop           in   consume head FIFO entry
//   irq_ack       in   clear sticky UE interrupt
//   ent_valid     out  FIFO non-empty
//   ent_data      out  head entry {ue, scrub, address}
//   fifo_level    out  entries held, 0..2^FIFO_LOGDEPTH
//   ce_cnt        out  corrected-event count (saturating)
//   ue_cnt        out  uncorrectable-event count (saturating)
//   ovf           out  sticky: an event was dropped on a full FIFO
//   irq_ue        out  sticky UE interrupt
// -----------------------------------------------------------------------------
module edac_err_logger #(
    parameter int ADDR_W        = 8,
    parameter int FIFO_LOGDEPTH = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     rClk,
    input  logic                     nGrst,
    input  logic                     correctable,
    input  logic                     error,
    input  logic                     now_scrubbing,
    input  logic [ADDR_W-1:0]        ram_rA_lat,
    input  logic                     clr,
    input  logic                     pop,
    input  logic                     irq_ack,
    output logic                     ent_valid,
    output logic [ADDR_W+1:0]        ent_data,
    output logic [FIFO_LOGDEPTH:0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     ce_cnt,
    output logic [CNT_WIDTH-1:0]     ue_cnt,
    output logic                     ovf,
    output logic                     irq_ue
);

    localparam int DEPTH = 1 << FIFO_LOGDEPTH;
    localparam int E_W   = ADDR_W + 2;
    localparam int P_W   = FIFO_LOGDEPTH + 1;

    // Input capture stage
    logic              s_ev;
    logic              s_ue;
    logic              s_scrub;
    logic [ADDR_W-1:0] s_addr;
    logic              s_pop;
    logic              s_clr;
    logic              s_ack;

    // FIFO and status state
    logic [E_W-1:0]       mem [DEPTH];
    logic [P_W-1:0]       wr_ptr;
    logic [P_W-1:0]       rd_ptr;
    logic [E_W-1:0]       head_q;
    logic [CNT_WIDTH-1:0] ce_q;
    logic [CNT_WIDTH-1:0] ue_q;
    logic                 ovf_q;
    logic                 irq_q;

    // Processing-stage decode
    logic           empty;
    logic           full;
    logic           dup;
    logic           want_push;
    logic           do_push;
    logic           do_pop;
    logic           drop;
    logic [P_W-1:0] wr_next;
    logic [P_W-1:0] rd_next;
    logic [E_W-1:0] push_data;

    always_ff @(posedge rClk or negedge nGrst) begin
        if (!nGrst) begin
            s_ev    <= 1'b0;
            s_ue    <= 1'b0;
            s_scrub <= 1'b0;
            s_addr  <= '0;
            s_pop   <= 1'b0;
            s_clr   <= 1'b0;
            s_ack   <= 1'b0;
        end else begin
            s_ev    <= error | correctable;
            s_ue    <= error;            // UE wins when both flags are high
            s_scrub <= now_scrubbing;
            s_addr  <= ram_rA_lat;
            s_pop   <= pop;
            s_clr   <= clr;
            s_ack   <= irq_ack;
        end
    end

`ifdef EDAC_ERRLOG_DEDUP_EN
    logic [ADDR_W:0] last_key;
    logic            last_valid;

    always_ff @(posedge rClk or negedge nGrst) begin
        if (!nGrst) begin
            last_key   <= '0;
            last_valid <= 1'b0;
        end else if (s_clr) begin
            last_valid <= 1'b0;
        end else if (do_push) begin
            last_key   <= {s_ue, s_addr};
            last_valid <= 1'b1;
        end
    end

    assign dup = last_valid && (last_key == {s_ue, s_addr});
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        // Same index, opposite lap bit
        full      = (wr_ptr[P_W-1] != rd_ptr[P_W-1]) &&
                    (wr_ptr[P_W-2:0] == rd_ptr[P_W-2:0]);
        do_pop    = s_pop && !empty;
        want_push = s_ev && !dup;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push   = want_push && (!full || do_pop);
        drop      = want_push && full && !do_pop;
        wr_next   = wr_ptr + {{(P_W-1){1'b0}}, do_push};
        rd_next   = rd_ptr + {{(P_W-1){1'b0}}, do_pop};
        push_data = {s_ue, s_scrub, s_addr};
    end

    // Storage is deliberately not reset
    always_ff @(posedge rClk) begin
        if (do_push && !s_clr) begin
            mem[wr_ptr[P_W-2:0]] <= push_data;
        end
    end

    always_ff @(posedge rClk or negedge nGrst) begin
        if (!nGrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
            ce_q   <= '0;
            ue_q   <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else if (s_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ce_q   <= '0;
            ue_q   <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;

            if (s_ev && !s_ue && (ce_q != '1)) begin
                ce_q <= ce_q + 1'b1;
            end
            if (s_ev && s_ue && (ue_q != '1)) begin
                ue_q <= ue_q + 1'b1;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end

            // Set has priority over acknowledge
            if (s_ev && s_ue) begin
                irq_q <= 1'b1;
            end else if (s_ack) begin
                irq_q <= 1'b0;
            end

            // Registered show-ahead head. The slot being written this edge is
            // not yet in mem, so a push landing at the new head bypasses it.
            if (do_push && (wr_ptr[P_W-2:0] == rd_next[P_W-2:0])) begin
                head_q <= push_data;
            end else if (wr_next != rd_next) begin
                head_q <= mem[rd_next[P_W-2:0]];
            end
        end
    end

    assign ent_valid  = (wr_ptr != rd_ptr);
    assign ent_data   = head_q;
    assign fifo_level = wr_ptr - rd_ptr;
    assign ce_cnt     = ce_q;
    assign ue_cnt     = ue_q;
    assign ovf        = ovf_q;
    assign irq_ue     = irq_q;

endmodule

// File: tb/tb_edac_err_logger.sv
// -----------------------------------------------------------------------------
// tb_edac_err_logger
//
// Self-checking bench for edac_err_logger with default parameters. A reference
// model tracks counters, sticky flags and the expected FIFO contents (exp_q);
// entries are pushed to exp_q as events are driven and compared against
// ent_data as they are popped. Honours EDAC_ERRLOG_DEDUP_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_edac_err_logger;

    localparam int ADDR_W = 8;
    localparam int LOGD   = 3;
    localparam int CW     = 16;
    localparam int DEPTH  = 1 << LOGD;

    // clock / reset
    logic rClk = 1'b0;
    logic nGrst;
    always #5 rClk = ~rClk;

    logic              correctable, error, now_scrubbing, clr, pop, irq_ack;
    logic [ADDR_W-1:0] ram_rA_lat;
    logic              ent_valid, ovf, irq_ue;
    logic [ADDR_W+1:0] ent_data;
    logic [LOGD:0]     fifo_level;
    logic [CW-1:0]     ce_cnt, ue_cnt;

    edac_err_logger #(.ADDR_W(ADDR_W), .FIFO_LOGDEPTH(LOGD), .CNT_WIDTH(CW)) dut (
        .rClk(rClk), .nGrst(nGrst), .correctable(correctable), .error(error),
        .now_scrubbing(now_scrubbing), .ram_rA_lat(ram_rA_lat), .clr(clr),
        .pop(pop), .irq_ack(irq_ack), .ent_valid(ent_valid), .ent_data(ent_data),
        .fifo_level(fifo_level), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .ovf(ovf),
        .irq_ue(irq_ue)
    );

    // scoreboard / model
    logic [ADDR_W+1:0] exp_q[$];
    logic [CW-1:0]     m_ce, m_ue;
    logic              m_ovf, m_irq, m_lv;
    logic [ADDR_W:0]   m_last;
    int                n_checks = 0;
    int                n_fail   = 0;

`ifdef EDAC_ERRLOG_DEDUP_EN
    localparam int DEDUP_L1 = 1;
    localparam int DEDUP_L2 = 3;
`else
    localparam int DEDUP_L1 = 3;
    localparam int DEDUP_L2 = 5;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ce = '0; m_ue = '0; m_ovf = 1'b0; m_irq = 1'b0; m_lv = 1'b0; m_last = '0;
    endtask

    // Drive one cycle of inputs; model reflects state once the DUT has
    // processed them (one more edge later).
    task automatic apply(input logic corr, input logic err, input logic scrub,
                         input logic [ADDR_W-1:0] addr, input logic p,
                         input logic c, input logic a);
        logic ev, ue, popping, dup, full_m;
        correctable = corr; error = err; now_scrubbing = scrub; ram_rA_lat = addr;
        pop = p; clr = c; irq_ack = a;
        @(posedge rClk); #1;
        correctable = 1'b0; error = 1'b0; now_scrubbing = 1'b0; pop = 1'b0;
        clr = 1'b0; irq_ack = 1'b0;
        ev = corr | err;
        ue = err;
        if (c) begin
            model_reset();
        end else begin
            popping = p && (exp_q.size() != 0);
            dup = 1'b0;
`ifdef EDAC_ERRLOG_DEDUP_EN
            dup = ev && m_lv && (m_last == {ue, addr});
`endif
            if (ev && ue) m_irq = 1'b1;
            else if (a)   m_irq = 1'b0;
            if (ev && !ue && m_ce != 16'hFFFF) m_ce = m_ce + 1'b1;
            if (ev &&  ue && m_ue != 16'hFFFF) m_ue = m_ue + 1'b1;
            full_m = (exp_q.size() == DEPTH);
            if (popping) void'(exp_q.pop_front());
            if (ev && !dup) begin
                if (!full_m || popping) begin
                    exp_q.push_back({ue, scrub, addr});
                    m_lv = 1'b1;
                    m_last = {ue, addr};
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ev_ce(input logic [ADDR_W-1:0] addr);
        apply(1'b1, 1'b0, 1'b0, addr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // Let the pipeline drain one edge, then compare everything.
    task automatic check_all(input string tag);
        idle();
        check_val({tag, ".ce_cnt"},     32'(ce_cnt),     32'(m_ce));
        check_val({tag, ".ue_cnt"},     32'(ue_cnt),     32'(m_ue));
        check_val({tag, ".fifo_level"}, 32'(fifo_level), 32'(exp_q.size()));
        check_val({tag, ".ent_valid"},  32'(ent_valid),  32'(exp_q.size() != 0));
        check_val({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
        check_val({tag, ".irq_ue"},     32'(irq_ue),     32'(m_irq));
        if (exp_q.size() != 0)
            check_val({tag, ".ent_data"}, 32'(ent_data), 32'(exp_q[0]));
    endtask

    // Compare the head against the scoreboard, then consume it.
    task automatic pop_check(input string tag);
        idle();
        check_val({tag, ".valid"}, 32'(ent_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check_val({tag, ".data"}, 32'(ent_data), 32'(exp_q[0]));
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".ce_cnt"},     32'(ce_cnt),     0);
        check_val({tag, ".ue_cnt"},     32'(ue_cnt),     0);
        check_val({tag, ".fifo_level"}, 32'(fifo_level), 0);
        check_val({tag, ".ent_valid"},  32'(ent_valid),  0);
        check_val({tag, ".ent_data"},   32'(ent_data),   0);
        check_val({tag, ".ovf"},        32'(ovf),        0);
        check_val({tag, ".irq_ue"},     32'(irq_ue),     0);
    endtask

    initial begin
        correctable = 1'b0; error = 1'b0; now_scrubbing = 1'b0; ram_rA_lat = '0;
        clr = 1'b0; pop = 1'b0; irq_ack = 1'b0;
        nGrst = 1'b0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge rClk); nGrst = 1'b1;
        @(posedge rClk); #1;

        // CE at 0x12, latency, then pop
        ev_ce(8'h12);
        check_val("lat.ce_cnt_not_yet", 32'(ce_cnt), 0);
        check_all("ce1");
        check_val("ce1.data_const", 32'(ent_data), 32'h012);
        pop_check("ce1.pop");
        check_all("ce1.after_pop");

        // Pop on empty has no effect
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_all("pop_empty");

        // UE with both flags, scrubbing
        do_clr();
        apply(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check_all("ue1");
        check_val("ue1.data_const", 32'(ent_data), 32'h3A5);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_all("ue1.ack");
        // UE and ack together: set wins
        apply(1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        check_all("ue.set_wins");

        // Overflow: 9 CE, then 8 ordered pops
        do_clr();
        for (int i = 0; i < 9; i++) ev_ce(8'(8'h20 + i));
        check_all("ovf9");
        check_val("ovf9.level_const", 32'(fifo_level), 8);
        check_val("ovf9.ovf_const",   32'(ovf), 1);
        for (int i = 0; i < 8; i++) pop_check("ovf9.pop");
        check_all("ovf9.drained");
        // Refill, then event with pop while full
        for (int i = 0; i < 8; i++) ev_ce(8'(8'h80 + i));
        check_all("refill");
        apply(1'b1, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0);
        check_all("full_push_pop");
        for (int i = 0; i < 8; i++) pop_check("refill.pop");
        check_all("refill.drained");

        // Throughput: random event + pop every cycle
        do_clr();
        for (int i = 0; i < 40; i++)
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check_all("random");
        while (exp_q.size() != 0) pop_check("random.pop");
        check_all("random.drained");

        // Clear coinciding with an event
        ev_ce(8'h55);
        apply(1'b0, 1'b1, 1'b0, 8'h56, 1'b0, 1'b1, 1'b0);
        check_all("clr_event");

        // Dedup sequence
        do_clr();
        for (int i = 0; i < 3; i++) ev_ce(8'h40);
        check_all("dedup1");
        check_val("dedup1.level_const", 32'(fifo_level), DEDUP_L1);
        ev_ce(8'h41);
        ev_ce(8'h40);
        check_all("dedup2");
        check_val("dedup2.level_const", 32'(fifo_level), DEDUP_L2);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) apply(1'b1, 1'(i & 1), 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
        correctable = 1'b1; ram_rA_lat = 8'hEF;
        @(posedge rClk); #3;
        nGrst = 1'b0;
        #1;
        check_zero("async_rst");
        correctable = 1'b0;
        @(negedge rClk); nGrst = 1'b1;
        model_reset();
        @(posedge rClk); #1;
        check_all("after_rst");

        // Saturation of ce_cnt
        do_clr();
        for (int i = 0; i < 65535; i++) ev_ce(8'(i));
        check_all("sat.preload");
        check_val("sat.preload_const", 32'(ce_cnt), 32'hFFFF);
        ev_ce(8'hF7);
        check_all("sat.hold");
        check_val("sat.hold_const", 32'(ce_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
